pulse_counter_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares one mod-4 pulse-counter FSM among N_REQ

---
 rtl/pulse_counter_arbiter_if.sv | 26 ++
 rtl/pulse_counter_arbiter.sv | 108 ++++++++++
 tb/tb_pulse_counter_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_counter_arbiter_if.sv
// Bundles the requester lines, the shared counter link and the grant/status outputs.
interface pulse_counter_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] pulse;
  logic [1:0]       cnt_state;
  logic             cnt_rstn;
  logic             x_out;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             done;
  logic             abort;

  modport master (
    output req, pulse, cnt_state,
    input  cnt_rstn, x_out, gnt, gnt_id, busy, done, abort
  );

  modport slave (
    input  req, pulse, cnt_state,
    output cnt_rstn, x_out, gnt, gnt_id, busy, done, abort
  );
endinterface

// File: rtl/pulse_counter_arbiter.sv
// Round-robin arbiter sharing one mod-4 pulse counter between N_REQ requesters; a grant
// ends on counter wrap (done), request drop or idle timeout (abort).
module pulse_counter_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  pulse_counter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClear, StOwn, StRelease} state_e;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic [ID_W-1:0]  last_q;
  logic             cnt_rstn_q;
  logic             done_q;
  logic             abort_q;
  logic [7:0]       timer_q;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic             own_req;
  logic             fwd;

  // Scan from farthest to nearest so the nearest requester after last_q wins.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_w;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    idx_w      = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      idx   = (32'(last_q) + i) % N_REQ;
      idx_w = ID_W'(idx);
      if (bus.req[idx_w]) begin
        pick_valid = 1'b1;
        pick_id    = idx_w;
      end
    end
  end

  assign own_req = bus.req[gnt_id_q];
  assign fwd     = own_req & bus.pulse[gnt_id_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      last_q     <= ID_W'(N_REQ - 1);
      cnt_rstn_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      timer_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_rstn_q <= 1'b1;
          gnt_q      <= '0;
          if (pick_valid) begin
            gnt_q      <= N_REQ'(1) << pick_id;
            gnt_id_q   <= pick_id;
            cnt_rstn_q <= 1'b0;
            state_q    <= StClear;
          end
        end
        StClear: begin
          cnt_rstn_q <= 1'b1;
          timer_q    <= '0;
          state_q    <= StOwn;
        end
        StOwn: begin
          if (!own_req || (fwd && bus.cnt_state == 2'b11) || (!fwd && timer_q == TimerLast)) begin
            done_q  <= own_req & fwd;
            abort_q <= ~(own_req & fwd);
            gnt_q   <= '0;
            last_q  <= gnt_id_q;
            state_q <= StRelease;
          end else if (fwd) begin
            timer_q <= '0;
          end else if (timer_q != 8'hff) begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign bus.cnt_rstn = cnt_rstn_q;
  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;
  assign bus.x_out    = (state_q == StOwn) & fwd;

endmodule

// File: tb/tb_pulse_counter_arbiter.sv
// Bench for pulse_counter_arbiter: directed scenarios plus random traffic, every cycle
// compared with a grant-level reference model and a behavioural mod-4 counter.
module tb_pulse_counter_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_counter_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

  pulse_counter_arbiter #(.N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared counter: cleared by cnt_rstn, advanced by x_out.
  logic [1:0] cnt = 2'd0;
  always @(posedge clk) cnt <= !bus.cnt_rstn ? 2'd0 : (bus.x_out ? cnt + 2'd1 : cnt);
  assign bus.cnt_state = cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the counter and how the current grant is progressing.
  int m_owner, m_gid, m_last, m_end, m_quiet, m_npulse;
  bit m_clear, m_rstn;

  // Observation logs for scenario-level checks.
  int         n_done, n_abort, n_x;
  int         grants[$];
  logic [3:0] prev_gnt;
  logic       last_x, last_abort;
  logic [1:0] last_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_update(input logic r, input logic [3:0] rq, input logic [3:0] p);
    bit found;
    int idx;
    if (r) begin
      m_owner = -1; m_gid = 0; m_last = N - 1; m_end = 0;
      m_quiet = 0; m_npulse = 0; m_clear = 0; m_rstn = 0;
      return;
    end
    if (m_end != 0) begin
      m_end = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int i = 1; i <= N; i++) begin
        idx = (m_last + i) % N;
        if (!found && rq[idx]) begin
          found = 1; m_owner = idx; m_gid = idx; m_clear = 1;
        end
      end
    end else if (m_clear) begin
      m_clear = 0; m_quiet = 0; m_npulse = 0;
    end else if (!rq[m_owner]) begin
      m_end = 2; m_last = m_owner; m_owner = -1;
    end else if (p[m_owner]) begin
      m_npulse++;
      m_quiet = 0;
      if (m_npulse == 4) begin
        m_end = 1; m_last = m_owner; m_owner = -1;
      end
    end else if (m_quiet == TO - 1) begin
      m_end = 2; m_last = m_owner; m_owner = -1;
    end else begin
      m_quiet++;
    end
    m_rstn = !m_clear;
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] p);
    logic [3:0] eg;
    logic       ex;
    rst = r; bus.req = rq; bus.pulse = p;
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    ex = (m_owner >= 0) && !m_clear && rq[m_owner] && p[m_owner];
    check("gnt", bus.gnt, eg);
    check("gnt_id", bus.gnt_id, m_gid);
    check("busy", bus.busy, (m_owner >= 0) || (m_end != 0));
    check("done", bus.done, m_end == 1);
    check("abort", bus.abort, m_end == 2);
    check("cnt_rstn", bus.cnt_rstn, m_rstn);
    check("x_out", bus.x_out, ex);
    if (bus.done) n_done++;
    if (bus.abort) n_abort++;
    if (bus.x_out) n_x++;
    if (bus.gnt != 0 && prev_gnt == 0) grants.push_back(int'(bus.gnt_id));
    prev_gnt   = bus.gnt;
    last_x     = bus.x_out;
    last_abort = bus.abort;
    last_cnt   = cnt;
    model_update(r, rq, p);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0, 4'b0);
    step(1'b1, 4'b0, 4'b0);
    n_done = 0; n_abort = 0; n_x = 0; grants.delete();
  endtask

  initial begin
    logic [3:0] rq, p;
    int dens, found_i;
    bit found;

    // Bring registers out of power-up state before any comparison.
    rst = 1'b1; bus.req = 4'hf; bus.pulse = 4'h0; prev_gnt = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_update(1'b1, 4'h0, 4'h0);

    // T1: reset held with all requesting, then first grant is requester 0.
    step(1'b1, 4'hf, 4'h0);
    n_done = 0; n_abort = 0; n_x = 0; grants.delete();
    repeat (3) step(1'b0, 4'hf, 4'h0);
    check("t1_first_grant", grants.size() > 0 ? grants[0] : -1, 0);

    // T2: four pulses on line 1 produce four x_out pulses and one done.
    do_reset();
    repeat (2) step(1'b0, 4'b0010, 4'b0000);
    repeat (4) step(1'b0, 4'b0010, 4'b0010);
    step(1'b0, 4'b0010, 4'b0000);
    check("t2_xout_count", n_x, 4);
    check("t2_done_count", n_done, 1);

    // T3: round-robin order 0,1,3,0 with a done per grant.
    do_reset();
    repeat (30) step(1'b0, 4'b1011, 4'b1111);
    check("t3_grant0", grants.size() > 0 ? grants[0] : -1, 0);
    check("t3_grant1", grants.size() > 1 ? grants[1] : -1, 1);
    check("t3_grant2", grants.size() > 2 ? grants[2] : -1, 3);
    check("t3_grant3", grants.size() > 3 ? grants[3] : -1, 0);
    check("t3_done_count", n_done, 4);
    check("t3_abort_count", n_abort, 0);

    // T4: owner drops req together with its pulse.
    do_reset();
    repeat (2) step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0000, 4'b0100);
    check("t4_xout", last_x, 1'b0);
    step(1'b0, 4'b0000, 4'b0000);
    check("t4_abort", last_abort, 1'b1);
    check("t4_done_count", n_done, 0);

    // T5: one pulse then silence; abort 16 cycles after the pulse, counter left at S1.
    do_reset();
    repeat (2) step(1'b0, 4'b0001, 4'b0000);
    step(1'b0, 4'b0001, 4'b0001);
    found = 0; found_i = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 4'b0001, 4'b0000);
      if (!found && last_abort) begin
        found = 1; found_i = i;
        check("t5_abort_latency", i, 16);
        check("t5_cnt_at_abort", last_cnt, 2'd1);
      end
      if (found && i == found_i + 3) check("t5_cnt_after_clear", last_cnt, 2'd0);
    end
    if (!found) check("t5_abort_seen", 0, 1);

    // T6: pulses on a non-granted line are ignored and the timer still expires.
    do_reset();
    repeat (2) step(1'b0, 4'b0001, 4'b0000);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, (i < 10) ? 4'b1000 : 4'b0000);
    check("t6_xout_count", n_x, 0);
    check("t6_abort_count", n_abort, 1);

    // Random traffic: sticky requests, varying pulse density, occasional reset.
    do_reset();
    rq = 4'b0; dens = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 3))
          0:       dens = 0;
          1:       dens = 5;
          2:       dens = 30;
          default: dens = 70;
        endcase
      end
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
        p[b] = ($urandom_range(0, 99) < dens);
      end
      step(($urandom_range(0, 399) == 0), rq, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
